// File: rtl/iopage_bus.sv
// iopage_bus: DCJ11 I/O-page bus initiator with one-hot device req/ack handshake,
// NXM on decode miss or timeout, and fixed-priority interrupt collection.
module iopage_bus #(
    parameter int                 NDEV     = 4,
    parameter logic [NDEV*13-1:0] DEV_BASE = {13'o17500, 13'o17400, 13'o17560, 13'o17546},
    parameter logic [NDEV*9-1:0]  DEV_VEC  = {9'o064, 9'o220, 9'o060, 9'o100},
    parameter int                 TIMEOUT  = 64
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               cpu_req,
    input  logic               cpu_wr,
    input  logic [12:0]        cpu_addr,
    input  logic [15:0]        cpu_wdata,
    output logic               cpu_ack,
    output logic               cpu_err,
    output logic [15:0]        cpu_rdata,
    output logic               cpu_irq,
    output logic [8:0]         cpu_vec,
    input  logic               cpu_iack,
    output logic [NDEV-1:0]    dev_req,
    output logic               dev_wr,
    output logic [2:0]         dev_addr,
    output logic [15:0]        dev_wdata,
    input  logic [NDEV-1:0]    dev_ack,
    input  logic [NDEV*16-1:0] dev_rdata,
    input  logic [NDEV-1:0]    dev_irq
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT, RECOV} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            hit, start, miss, ack_sel, tmo, done;
    logic [NDEV-1:0] hit_oh, pending, clr;
    logic [15:0]     sel_rdata;
    logic            addr_unused;

    assign addr_unused = cpu_addr[0];

    // Descending scan so the lowest matching window wins.
    always_comb begin
        hit       = 1'b0;
        hit_oh    = '0;
        sel_rdata = '0;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (cpu_addr[12:4] == DEV_BASE[i*13+4 +: 9]) begin
                hit    = 1'b1;
                hit_oh = NDEV'(1) << i;
            end
            sel_rdata |= dev_rdata[i*16 +: 16] & {16{dev_req[i]}};
        end
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = start && hit ? WAIT : IDLE;
            WAIT:    state_nxt = done ? RECOV : WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start   = state == IDLE && cpu_req;
        miss    = start && !hit;
        ack_sel = |(dev_ack & dev_req);
        tmo     = cnt == CW'(TIMEOUT - 1);
        done    = state == WAIT && (ack_sel || tmo);
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            cpu_ack   <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
            dev_req   <= '0;
            dev_wr    <= 1'b0;
            dev_addr  <= '0;
            dev_wdata <= '0;
            cnt       <= '0;
        end else begin
            cpu_ack <= miss || done;
            if (start) begin
                dev_req   <= hit_oh;
                dev_wr    <= cpu_wr;
                dev_addr  <= cpu_addr[3:1];
                dev_wdata <= cpu_wdata;
                cnt       <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + 1'b1;
            end
            if (done) dev_req <= '0;
            // A sampled ack beats a simultaneous timeout.
            if (miss || done) begin
                cpu_err   <= miss || !ack_sel;
                cpu_rdata <= ack_sel && !dev_wr ? sel_rdata : '0;
            end
        end

    // iack retires the lowest pending device; a same-edge pulse re-sets it.
    assign clr = cpu_iack ? pending & (~pending + 1'b1) : '0;

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) pending <= '0;
        else       pending <= (pending & ~clr) | dev_irq;

    always_comb begin
        cpu_irq = |pending;
        cpu_vec = '0;
        for (int i = NDEV - 1; i >= 0; i--)
            if (pending[i]) cpu_vec = DEV_VEC[i*9 +: 9];
    end
endmodule

// File: tb/tb_iopage_bus.sv
// tb_iopage_bus: scoreboard bench for iopage_bus with registered-ack device models,
// stray/late ack injection, timeout, interrupt priority and async reset checks.
module tb_iopage_bus;
    localparam int         NDEV = 4;
    localparam int         TMO  = 8;
    localparam logic [8:0] VEC0 = 9'o100, VEC1 = 9'o060, VEC2 = 9'o220, VEC3 = 9'o064;
    localparam logic [NDEV*13-1:0] BASES = {13'o17560, 13'o17400, 13'o17560, 13'o17546};

    typedef struct {
        int          cyc;
        logic        err;
        logic [15:0] rdata;
    } exp_t;

    logic              clk = 1'b0, rstn = 1'b1;
    logic              cpu_req = 1'b0, cpu_wr = 1'b0, cpu_iack = 1'b0;
    logic [12:0]       cpu_addr = '0;
    logic [15:0]       cpu_wdata = '0;
    logic              cpu_ack, cpu_err, cpu_irq, dev_wr;
    logic [15:0]       cpu_rdata, dev_wdata;
    logic [8:0]        cpu_vec;
    logic [2:0]        dev_addr;
    logic [NDEV-1:0]   dev_req, dev_ack, dev_irq = '0;
    logic [NDEV-1:0]   ack_q, ack_en = '1, stray = '0;
    logic [NDEV*16-1:0] dev_rdata = {16'h5a5a, 16'hbeef, 16'o001234, 16'o000200};

    exp_t sb[$];
    exp_t e;
    int   cyc = 0, n_vec = 0, n_bad = 0;

    iopage_bus #(.NDEV(NDEV), .DEV_BASE(BASES), .DEV_VEC({VEC3, VEC2, VEC1, VEC0}),
                 .TIMEOUT(TMO)) dut (
        .clk(clk), .rstn(rstn), .cpu_req(cpu_req), .cpu_wr(cpu_wr),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
        .cpu_rdata(cpu_rdata), .cpu_irq(cpu_irq), .cpu_vec(cpu_vec), .cpu_iack(cpu_iack),
        .dev_req(dev_req), .dev_wr(dev_wr), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
        .dev_ack(dev_ack), .dev_rdata(dev_rdata), .dev_irq(dev_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rstn)
        if (!rstn) ack_q <= '0;
        else       ack_q <= dev_req & ack_en;
    assign dev_ack = ack_q | stray;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk)
        if (cpu_ack) begin
            if (sb.size() == 0) chk("spurious_ack", 1, 0);
            else begin
                e = sb.pop_front();
                chk("ack_cycle", cyc, e.cyc);
                chk("ack_err", cpu_err, e.err);
                chk("ack_rdata", cpu_rdata, e.rdata);
            end
        end

    task automatic xfer(input logic wr, input logic [12:0] addr, input logic [15:0] wd,
                        input logic [3:0] oh, input logic err, input logic [15:0] rd,
                        input int lat, input int nreq, input int late_k,
                        input logic [3:0] late_v, input logic recov);
        int  n = 0;
        logic got = 1'b0;
        sb.push_back('{cyc + lat, err, rd});
        cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wd;
        step();
        cpu_req = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (dev_req != 0) begin
                n++;
                chk("req_onehot", dev_req, oh);
                chk("req_fields", {dev_wr, dev_addr, dev_wdata}, {wr, addr[3:1], wd});
            end
            if (cpu_ack) begin
                got = 1'b1;
                break;
            end
            if (k == late_k) stray = late_v;
            step();
        end
        if (!got) chk("ack_bound", 0, 1);
        chk("req_cycles", n, nreq);
        if (recov) step();
    endtask

    initial begin
        #2 rstn = 1'b0;
        #1;
        chk("rst_ack", cpu_ack, 0);
        chk("rst_req", dev_req, 0);
        chk("rst_irq", {cpu_irq, cpu_vec}, 0);
        chk("rst_rdata", {cpu_err, cpu_rdata}, 0);
        step(); step();
        rstn = 1'b1;
        step();

        xfer(0, 13'o17546, 0, 4'b0001, 0, 16'o000200, 3, 2, -1, 0, 1);
        chk("rdata_hold", cpu_rdata, 16'o000200);
        xfer(1, 13'o17402, 16'o000100, 4'b0100, 0, 16'o0, 3, 2, -1, 0, 1);
        xfer(0, 13'o17000, 0, 4'b0000, 1, 16'o0, 1, 0, -1, 0, 0);
        xfer(0, 13'o17562, 0, 4'b0010, 0, 16'o001234, 3, 2, -1, 0, 1);
        xfer(0, 13'o17416, 0, 4'b0100, 0, 16'hbeef, 3, 2, -1, 0, 1);

        ack_en = 4'b1110; stray = 4'b1110;
        xfer(0, 13'o17546, 0, 4'b0001, 1, 16'o0, TMO + 1, TMO, -1, 0, 0);
        stray = '0;
        cpu_req = 1'b1; cpu_addr = 13'o17400; cpu_wr = 1'b0;
        step();
        cpu_req = 1'b0;
        chk("recov_drop", dev_req, 0);
        step();
        chk("recov_drop2", {dev_req, cpu_ack}, 0);

        xfer(0, 13'o17546, 0, 4'b0001, 0, 16'o000200, TMO + 1, TMO, TMO - 1, 4'b0001, 0);
        stray = '0; ack_en = '1;
        step();

        dev_irq = 4'b0100; step(); dev_irq = '0;
        chk("irq_2", {cpu_irq, cpu_vec}, {1'b1, VEC2});
        dev_irq = 4'b0001; step(); dev_irq = '0;
        chk("irq_prio", {cpu_irq, cpu_vec}, {1'b1, VEC0});
        cpu_iack = 1'b1; step(); cpu_iack = 1'b0;
        chk("iack_1", {cpu_irq, cpu_vec}, {1'b1, VEC2});
        cpu_iack = 1'b1; step(); cpu_iack = 1'b0;
        chk("iack_2", {cpu_irq, cpu_vec}, 10'd0);
        cpu_iack = 1'b1; step(); cpu_iack = 1'b0;
        chk("iack_none", {cpu_irq, cpu_vec}, 10'd0);
        dev_irq = 4'b1000; step(); dev_irq = '0;
        chk("irq_3", {cpu_irq, cpu_vec}, {1'b1, VEC3});
        dev_irq = 4'b0001; step(); dev_irq = '0;
        cpu_iack = 1'b1; dev_irq = 4'b0001; step(); cpu_iack = 1'b0; dev_irq = '0;
        chk("set_wins", {cpu_irq, cpu_vec}, {1'b1, VEC0});
        cpu_iack = 1'b1; step(); cpu_iack = 1'b0;
        chk("after_set_wins", {cpu_irq, cpu_vec}, {1'b1, VEC3});
        cpu_iack = 1'b1; step(); cpu_iack = 1'b0;

        dev_irq = 4'b0010; step(); dev_irq = '0;
        ack_en = 4'b1110;
        cpu_req = 1'b1; cpu_addr = 13'o17546; cpu_wr = 1'b0;
        step();
        cpu_req = 1'b0;
        step();
        chk("rst_pre_req", {cpu_irq, dev_req}, {1'b1, 4'b0001});
        #2 rstn = 1'b0;
        #1;
        chk("rst_mid_req", {dev_req, cpu_ack}, 0);
        chk("rst_mid_irq", {cpu_irq, cpu_vec}, 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        ack_en = '1;
        xfer(0, 13'o17546, 0, 4'b0001, 0, 16'o000200, 3, 2, -1, 0, 1);
        step();
        chk("sb_left", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got hang want finish");
        $fatal(1);
    end
endmodule
